// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-sequencer signal bundle: hazard sources toward the controller, stage
// enables/flushes and the timeout flag back to the pipeline.
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_is_load;
  logic       ex_pc_sel;
  logic       mem_req;
  logic       dmem_ready;

  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       mem_timeout_err;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
           ex_pc_sel, mem_req, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
           idex_flush, mem_timeout_err
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
           ex_pc_sel, mem_req, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
           idex_flush, mem_timeout_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline with a data-memory wait FSM.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles / flush_events counters.
//
// state    | meaning
// RUN      | normal flow; branch flush and load-use bubble resolved here
// MEM_WAIT | data memory busy; pipeline frozen, wait cycles counted
// ERROR    | memory timed out; frozen until rst_n
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic load_use;
  logic mem_miss;
  logic advance;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush;

  assign load_use = hz.ex_is_load && (hz.ex_rd != 5'd0) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  assign mem_miss = hz.mem_req && !hz.dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    advance = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_miss) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!hz.dmem_ready) begin
          if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // Release cycle moves the pipeline and still honours branch/load-use.
          state_d = RUN;
          cnt_d   = '0;
          advance = 1'b1;
        end
      end
      ERROR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    if (advance && rst_n) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (hz.ex_pc_sel) begin
        // The ID instruction dies with the flush, so a load-use there is moot.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  assign hz.pc_en           = pc_en;
  assign hz.ifid_en         = ifid_en;
  assign hz.idex_en         = idex_en;
  assign hz.exmem_en        = exmem_en;
  assign hz.memwb_en        = memwb_en;
  assign hz.ifid_flush      = ifid_flush;
  assign hz.idex_flush      = idex_flush;
  assign hz.mem_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!pc_en && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (ifid_flush && (flush_events_q != 32'hFFFF_FFFF))
      flush_events_d = flush_events_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule
